// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg : shared types for the dual-issue memory stage
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    LL_W  = 3'd5
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } mem_state_e;

  // Per-lane fields that travel untouched from execute to write-back.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic        excp;
    logic [5:0]  ecode;
  } sideband_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ---------------------------------------------------------------------------
// mem_stage_load_align : selects and extends load data from an aligned word
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage_load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = mem_stage_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        load_type_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[{offset_i, 3'b000} +: 8];
    // Half-word select ignores offset bit 0; misalignment is trapped upstream.
    w_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (load_type_e'(load_type_i))
      LD_B:    data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_H:    data_o = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, w_byte};
      LD_HU:   data_o = {{(DATA_W-16){1'b0}}, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage : dual-issue memory stage, one dcache port, load alignment/stall
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int REG_AW = mem_stage_pkg::REG_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [1:0]            ex_valid_i,
  input  logic [1:0]            ex_reg_write_en_i,
  input  logic [REG_AW-1:0]     ex_reg_write_addr1_i,
  input  logic [REG_AW-1:0]     ex_reg_write_addr2_i,
  input  logic [DATA_W-1:0]     ex_alu_result1_i,
  input  logic [DATA_W-1:0]     ex_alu_result2_i,
  input  logic                  ex_mem_lane_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_is_store_i,
  input  logic [2:0]            ex_load_type_i,
  input  logic                  ex_is_sc_i,
  input  logic                  llbit_i,
  input  sideband_t [1:0]       ex_sideband_i,
  input  logic                  dcache_rvalid_i,
  input  logic [DATA_W-1:0]     dcache_rdata_i,
  output logic [1:0]            mem_reg_write_en_o,
  output logic [REG_AW-1:0]     mem_reg_write_addr1_o,
  output logic [REG_AW-1:0]     mem_reg_write_addr2_o,
  output logic [DATA_W-1:0]     mem_reg_write_data1_o,
  output logic [DATA_W-1:0]     mem_reg_write_data2_o,
  output logic [1:0]            mem_commit_valid_o,
  output sideband_t [1:0]       mem_sideband_o,
  output logic                  pause_mem_o
);

  mem_state_e        state_q, state_d;
  logic              w_load;
  logic              w_commit;
  logic              w_pause;
  logic [1:0]        w_offset;
  logic [DATA_W-1:0] w_aligned;
  logic [DATA_W-1:0] w_mem_data;

  // A store-flagged op never waits on the read port, even if is_load is set.
  assign w_load   = ex_is_load_i & ~ex_is_store_i & ex_valid_i[ex_mem_lane_i];
  assign w_offset = ex_mem_lane_i ? ex_alu_result2_i[1:0] : ex_alu_result1_i[1:0];

  mem_stage_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata_i     (dcache_rdata_i),
    .offset_i    (w_offset),
    .load_type_i (ex_load_type_i),
    .data_o      (w_aligned)
  );

  always_comb begin
    if (ex_is_load_i) begin
      w_mem_data = w_aligned;
    end else if (ex_is_sc_i) begin
      w_mem_data = {{(DATA_W-1){1'b0}}, llbit_i};
    end else begin
      w_mem_data = ex_mem_lane_i ? ex_alu_result2_i : ex_alu_result1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w_commit = 1'b0;
    w_pause  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          w_commit = 1'b0;
        end else if (w_load && !dcache_rvalid_i) begin
          w_pause = 1'b1;
          state_d = ST_WAIT;
        end else begin
          w_commit = 1'b1;
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          state_d = dcache_rvalid_i ? ST_IDLE : ST_DRAIN;
        end else if (dcache_rvalid_i) begin
          w_commit = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          w_pause = 1'b1;
        end
      end
      ST_DRAIN: begin
        // A late reply would be mistaken for a new load's data, so hold it off.
        w_pause = w_load;
        if (dcache_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_reg_write_en_o    = '0;
    mem_reg_write_addr1_o = '0;
    mem_reg_write_addr2_o = '0;
    mem_reg_write_data1_o = '0;
    mem_reg_write_data2_o = '0;
    mem_commit_valid_o    = '0;
    mem_sideband_o        = '0;
    pause_mem_o           = 1'b0;
    if (!rst) begin
      mem_commit_valid_o    = ex_valid_i & {2{w_commit}};
      mem_reg_write_en_o    = ex_reg_write_en_i & ex_valid_i & {2{w_commit}};
      mem_reg_write_addr1_o = ex_reg_write_addr1_i;
      mem_reg_write_addr2_o = ex_reg_write_addr2_i;
      mem_reg_write_data1_o = ex_mem_lane_i ? ex_alu_result1_i : w_mem_data;
      mem_reg_write_data2_o = ex_mem_lane_i ? w_mem_data : ex_alu_result2_i;
      mem_sideband_o        = ex_sideband_i;
      pause_mem_o           = w_pause;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage : vector table plus multi-cycle load/flush/reset sequences
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [1:0]      ex_valid, ex_we;
  logic [4:0]      ex_a1, ex_a2;
  logic [31:0]     alu1, alu2;
  logic            lane, is_load, is_store, is_sc, llbit;
  logic [2:0]      ltype;
  sideband_t [1:0] sb_in, sb_out;
  logic            rvalid;
  logic [31:0]     rdata;
  logic [1:0]      o_we, o_commit;
  logic [4:0]      o_a1, o_a2;
  logic [31:0]     o_d1, o_d2;
  logic            o_pause;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_i               (flush),
    .ex_valid_i            (ex_valid),
    .ex_reg_write_en_i     (ex_we),
    .ex_reg_write_addr1_i  (ex_a1),
    .ex_reg_write_addr2_i  (ex_a2),
    .ex_alu_result1_i      (alu1),
    .ex_alu_result2_i      (alu2),
    .ex_mem_lane_i         (lane),
    .ex_is_load_i          (is_load),
    .ex_is_store_i         (is_store),
    .ex_load_type_i        (ltype),
    .ex_is_sc_i            (is_sc),
    .llbit_i               (llbit),
    .ex_sideband_i         (sb_in),
    .dcache_rvalid_i       (rvalid),
    .dcache_rdata_i        (rdata),
    .mem_reg_write_en_o    (o_we),
    .mem_reg_write_addr1_o (o_a1),
    .mem_reg_write_addr2_o (o_a2),
    .mem_reg_write_data1_o (o_d1),
    .mem_reg_write_data2_o (o_d2),
    .mem_commit_valid_o    (o_commit),
    .mem_sideband_o        (sb_out),
    .pause_mem_o           (o_pause)
  );

  typedef struct {
    logic [1:0]  valid, we;
    logic [31:0] alu1, alu2;
    logic        lane, is_load, is_store, is_sc, llbit, flush, rvalid;
    logic [2:0]  ltype;
    logic [31:0] rdata;
  } in_t;

  typedef struct {
    logic [1:0]  commit, we;
    logic [31:0] d1, d2;
    logic        pause, zero;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  ex;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  function automatic in_t alu_pair(logic [31:0] a, logic [31:0] b);
    in_t v;
    v = '{valid: 2'b11, we: 2'b11, alu1: a, alu2: b, lane: 1'b0, is_load: 1'b0,
          is_store: 1'b0, is_sc: 1'b0, llbit: 1'b0, flush: 1'b0, rvalid: 1'b0,
          ltype: 3'd0, rdata: 32'h0};
    return v;
  endfunction

  function automatic in_t ld(logic ln, logic [2:0] t, logic [31:0] va, logic rv, logic [31:0] rd);
    in_t v;
    v = alu_pair(32'h12, 32'h34);
    v.lane = ln; v.is_load = 1'b1; v.ltype = t; v.rvalid = rv; v.rdata = rd;
    if (ln) v.alu2 = va; else v.alu1 = va;
    return v;
  endfunction

  function automatic exp_t mk(logic [1:0] c, logic [1:0] w, logic [31:0] a, logic [31:0] b, logic p);
    exp_t e;
    e = '{commit: c, we: w, d1: a, d2: b, pause: p, zero: 1'b0};
    return e;
  endfunction

  task automatic apply(in_t v);
    ex_valid = v.valid; ex_we = v.we; alu1 = v.alu1; alu2 = v.alu2;
    lane = v.lane; is_load = v.is_load; is_store = v.is_store; is_sc = v.is_sc;
    llbit = v.llbit; flush = v.flush; rvalid = v.rvalid; ltype = v.ltype; rdata = v.rdata;
  endtask

  task automatic cmp(string name, string field, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic step(string name, in_t v, exp_t e);
    exp_t x;
    apply(v);
    sbq.push_back(e);
    @(negedge clk);
    x = sbq.pop_front();
    cmp(name, "commit", {30'b0, o_commit}, {30'b0, x.commit});
    cmp(name, "we",     {30'b0, o_we},     {30'b0, x.we});
    cmp(name, "data1",  o_d1, x.d1);
    cmp(name, "data2",  o_d2, x.d2);
    cmp(name, "pause",  {31'b0, o_pause}, {31'b0, x.pause});
    cmp(name, "addr1",  {27'b0, o_a1}, x.zero ? 32'h0 : 32'd1);
    cmp(name, "addr2",  {27'b0, o_a2}, x.zero ? 32'h0 : 32'd2);
    cmp(name, "sb_pc1", sb_out[1].pc, x.zero ? 32'h0 : sb_in[1].pc);
    cmp(name, "sb_ecode0", {26'b0, sb_out[0].ecode}, x.zero ? 32'h0 : {26'b0, sb_in[0].ecode});
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  v;
    exp_t e;
    exp_t ez;

    vecs[0]  = '{"alu_pair", alu_pair(32'h12, 32'h34), mk(2'b11, 2'b11, 32'h12, 32'h34, 1'b0)};
    vecs[1]  = '{"ld_hu_hit", ld(1'b0, 3'd4, 32'h1002, 1'b1, 32'hBEEF_1234),
                 mk(2'b11, 2'b11, 32'h0000_BEEF, 32'h34, 1'b0)};
    vecs[2]  = '{"ld_b_hit", ld(1'b0, 3'd0, 32'h1001, 1'b1, 32'h0000_8000),
                 mk(2'b11, 2'b11, 32'hFFFF_FF80, 32'h34, 1'b0)};
    vecs[3]  = '{"ld_bu_hit", ld(1'b1, 3'd3, 32'h2003, 1'b1, 32'h7F00_0000),
                 mk(2'b11, 2'b11, 32'h12, 32'h0000_007F, 1'b0)};
    vecs[4]  = '{"ld_h_hit", ld(1'b1, 3'd1, 32'h2000, 1'b1, 32'h1234_8001),
                 mk(2'b11, 2'b11, 32'h12, 32'hFFFF_8001, 1'b0)};
    vecs[5]  = '{"ld_w_hit", ld(1'b0, 3'd2, 32'h3003, 1'b1, 32'hCAFE_F00D),
                 mk(2'b11, 2'b11, 32'hCAFE_F00D, 32'h34, 1'b0)};
    vecs[6]  = '{"ll_w_hit", ld(1'b1, 3'd5, 32'h0010, 1'b1, 32'h0BAD_F00D),
                 mk(2'b11, 2'b11, 32'h12, 32'h0BAD_F00D, 1'b0)};
    v = alu_pair(32'h4000, 32'h34); v.is_store = 1'b1; v.is_sc = 1'b1; v.llbit = 1'b1;
    vecs[7]  = '{"sc_llbit1", v, mk(2'b11, 2'b11, 32'h1, 32'h34, 1'b0)};
    v = alu_pair(32'h12, 32'h4444); v.lane = 1'b1; v.is_store = 1'b1; v.is_sc = 1'b1;
    vecs[8]  = '{"sc_llbit0", v, mk(2'b11, 2'b11, 32'h12, 32'h0, 1'b0)};
    v = alu_pair(32'h5000, 32'h34); v.is_store = 1'b1; v.we = 2'b00;
    vecs[9]  = '{"store", v, mk(2'b11, 2'b00, 32'h5000, 32'h34, 1'b0)};
    v = alu_pair(32'h55, 32'h66); v.flush = 1'b1;
    vecs[10] = '{"flush_idle", v, mk(2'b00, 2'b00, 32'h55, 32'h66, 1'b0)};
    v = alu_pair(32'h77, 32'h88); v.valid = 2'b01;
    vecs[11] = '{"lane1_invalid", v, mk(2'b01, 2'b01, 32'h77, 32'h88, 1'b0)};

    for (int i = 0; i < 2; i++) begin
      sb_in[i].pc        = 32'h1C00_0000 + 32'(i * 4);
      sb_in[i].inst      = 32'h0280_0000 | 32'(i);
      sb_in[i].csr_we    = i[0];
      sb_in[i].csr_num   = 14'h0005 + 14'(i);
      sb_in[i].csr_wdata = 32'hA5A5_0000 + 32'(i);
      sb_in[i].excp      = ~i[0];
      sb_in[i].ecode     = 6'h0B + 6'(i);
    end
    ex_a1 = 5'd1;
    ex_a2 = 5'd2;

    ez = mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    ez.zero = 1'b1;
    rst = 1'b1;
    #1;
    step("reset", alu_pair(32'h12, 32'h34), ez);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].name, vecs[i].in, vecs[i].ex);
    end

    // ld.b lane 1 with the reply three cycles late
    v = ld(1'b1, 3'd0, 32'h6003, 1'b0, 32'h0);
    e = mk(2'b00, 2'b00, 32'h12, 32'hFFFF_FFFF, 1'b1);
    for (int c = 0; c < 3; c++) begin
      v.rdata = 32'h0000_00FF;
      e.d2    = 32'h0000_0000;
      step("ldb_late_wait", v, e);
    end
    v.rvalid = 1'b1; v.rdata = 32'h80FF_0000;
    step("ldb_late_data", v, mk(2'b11, 2'b11, 32'h12, 32'hFFFF_FF80, 1'b0));
    step("ldb_late_after", alu_pair(32'h21, 32'h43), mk(2'b11, 2'b11, 32'h21, 32'h43, 1'b0));

    // flush while waiting, late reply discarded in DRAIN
    v = ld(1'b0, 3'd2, 32'h7000, 1'b0, 32'h0);
    step("fl_issue", v, mk(2'b00, 2'b00, 32'h0, 32'h34, 1'b1));
    v.flush = 1'b1;
    step("fl_flush", v, mk(2'b00, 2'b00, 32'h0, 32'h34, 1'b0));
    step("fl_drain_alu", alu_pair(32'h99, 32'hAA), mk(2'b00, 2'b00, 32'h99, 32'hAA, 1'b0));
    v = ld(1'b0, 3'd2, 32'h7100, 1'b1, 32'hDEAD_BEEF);
    step("fl_drain_reply", v, mk(2'b00, 2'b00, 32'hDEAD_BEEF, 32'h34, 1'b1));
    v.rvalid = 1'b0; v.rdata = 32'h0;
    step("fl_new_issue", v, mk(2'b00, 2'b00, 32'h0, 32'h34, 1'b1));
    v.rvalid = 1'b1; v.rdata = 32'h1111_2222;
    step("fl_new_data", v, mk(2'b11, 2'b11, 32'h1111_2222, 32'h34, 1'b0));

    // flush coinciding with the reply goes straight back to IDLE
    v = ld(1'b1, 3'd2, 32'h8000, 1'b0, 32'h0);
    step("flrv_issue", v, mk(2'b00, 2'b00, 32'h12, 32'h0, 1'b1));
    v.flush = 1'b1; v.rvalid = 1'b1; v.rdata = 32'h3333_4444;
    step("flrv_flush", v, mk(2'b00, 2'b00, 32'h12, 32'h3333_4444, 1'b0));
    step("flrv_idle", alu_pair(32'hB1, 32'hB2), mk(2'b11, 2'b11, 32'hB1, 32'hB2, 1'b0));

    // reset while waiting
    v = ld(1'b0, 3'd2, 32'h9000, 1'b0, 32'h0);
    step("rst_issue", v, mk(2'b00, 2'b00, 32'h0, 32'h34, 1'b1));
    step("rst_wait", v, mk(2'b00, 2'b00, 32'h0, 32'h34, 1'b1));
    rst = 1'b1;
    step("rst_mid_wait", v, ez);
    rst = 1'b0;
    step("rst_after", alu_pair(32'hC1, 32'hC2), mk(2'b11, 2'b11, 32'hC1, 32'hC2, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
